// File: rtl/sig_encode_out_if.sv
// Symbol-in / serial-out bundle for the sig_encode_out transmitter.
// The master drives symbols and Enable; the slave (encoder) returns Ready, the line and status.
interface sig_encode_out_if;
  logic       Enable;
  logic [1:0] Data_In;
  logic       Data_Valid;
  logic       Ready;
  logic       Data_Out;
  logic       Busy;
  logic       Sym_Err;

  modport master (
    output Enable,
    output Data_In,
    output Data_Valid,
    input  Ready,
    input  Data_Out,
    input  Busy,
    input  Sym_Err
  );

  modport slave (
    input  Enable,
    input  Data_In,
    input  Data_Valid,
    output Ready,
    output Data_Out,
    output Busy,
    output Sym_Err
  );
endinterface

// File: rtl/sig_encode_out.sv
// Serial symbol transmitter: 2-bit symbols are queued in a FIFO and sent as 4-bit line frames.
// Define SIG_ENCODE_GAP_EN to insert GAP_BITS idle-low cycles after every frame.
module sig_encode_out #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned GAP_BITS = 2
) (
  input logic             clk,
  input logic             Reset,
  sig_encode_out_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
`ifdef SIG_ENCODE_GAP_EN
  localparam int unsigned SeqW = (GAP_BITS > 4) ? $clog2(GAP_BITS) : 2;
  localparam logic [SeqW-1:0] GapLast = SeqW'(GAP_BITS - 1);
`else
  localparam int unsigned SeqW = 2;
`endif
  localparam logic [SeqW-1:0] FrameLast = SeqW'(3);

  typedef enum logic [1:0] {
    StIdle,
    StSend
`ifdef SIG_ENCODE_GAP_EN
    , StGap
`endif
  } state_e;

  // FIFO storage and bookkeeping
  logic [1:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty, accept, sym_legal, push, pop;

  // Serializer state
  state_e          state_q, state_d;
  logic [SeqW-1:0] seq_q, seq_d;
  logic [2:0]      shreg_q, shreg_d;
  logic            line_q, line_d;
  logic            sym_err_q;
  logic            start;
  logic            load_slot;
  logic [3:0]      head_frame;

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign accept    = bus.Data_Valid && !full;
  assign sym_legal = (bus.Data_In == 2'b01) || (bus.Data_In == 2'b10);
  assign push      = accept && sym_legal;
  assign start     = !empty && bus.Enable;

  // Frame bit 0 goes on the line first: 01 -> 1,1,1,0 and 10 -> 1,0,0,0.
  assign head_frame = (mem_q[rd_ptr_q] == 2'b01) ? 4'b0111 : 4'b0001;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    shreg_d   = shreg_q;
    line_d    = 1'b0;
    pop       = 1'b0;
    load_slot = 1'b0;

    unique case (state_q)
      StIdle: load_slot = 1'b1;
      StSend: begin
        if (seq_q != FrameLast) begin
          line_d  = shreg_q[0];
          shreg_d = {1'b0, shreg_q[2:1]};
          seq_d   = seq_q + SeqW'(1);
        end else begin
`ifdef SIG_ENCODE_GAP_EN
          state_d = StGap;
          seq_d   = '0;
`else
          load_slot = 1'b1;
`endif
        end
      end
`ifdef SIG_ENCODE_GAP_EN
      StGap: begin
        if (seq_q != GapLast) begin
          seq_d = seq_q + SeqW'(1);
        end else begin
          load_slot = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Shared frame-boundary rule: start the next frame immediately or fall back to idle.
    if (load_slot) begin
      if (start) begin
        pop     = 1'b1;
        line_d  = head_frame[0];
        shreg_d = head_frame[3:1];
        seq_d   = '0;
        state_d = StSend;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.Data_In;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      seq_q     <= '0;
      shreg_q   <= '0;
      line_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sym_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      shreg_q   <= shreg_d;
      line_q    <= line_d;
      count_q   <= count_d;
      sym_err_q <= accept && !sym_legal;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  assign bus.Ready    = !full;
  assign bus.Data_Out = line_q;
  assign bus.Busy     = (state_q != StIdle) || !empty;
  assign bus.Sym_Err  = sym_err_q;

endmodule

// File: tb/tb_sig_encode_out.sv
// Scoreboard bench for sig_encode_out: accepted symbols queue their expected line frame,
// and a line monitor parses frames off Data_Out and compares them in order.
module tb_sig_encode_out;
  localparam int unsigned Depth = 4;
`ifdef SIG_ENCODE_GAP_EN
  localparam int GapBits = 2;
`else
  localparam int GapBits = 0;
`endif

  logic clk = 1'b0;
  logic Reset;

  sig_encode_out_if bus ();

  sig_encode_out #(
    .DEPTH    (Depth),
    .GAP_BITS (2)
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [3:0] exp_q [$];
  int starts [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected completion (cycle %0d)", name, cyc);
  endtask

  // Line monitor: a frame always starts with a 1, so a high bit outside a frame opens one.
  logic       in_frame = 1'b0;
  int         nbits = 0;
  logic [3:0] frm = 4'b0;
  always @(negedge clk) begin
    if (Reset) begin
      in_frame = 1'b0;
    end else if (in_frame) begin
      frm = {frm[2:0], bus.Data_Out};
      nbits++;
      if (nbits == 4) begin
        in_frame = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame: got unexpected %b expected none", frm);
        end else begin
          check("frame", frm, exp_q.pop_front());
        end
      end
    end else if (bus.Data_Out) begin
      in_frame = 1'b1;
      nbits = 1;
      frm = 4'b0001;
      starts.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sym, input logic [3:0] frame, input bit legal);
    int n = 0;
    bus.Data_In = sym;
    bus.Data_Valid = 1'b1;
    while (!bus.Ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.Ready) begin
      fail("push_ready");
    end
    tick();
    bus.Data_Valid = 1'b0;
    if (legal) exp_q.push_back(frame);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.Busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_reached", bus.Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] b2;
    Reset = 1'b1;
    bus.Enable = 1'b1;
    bus.Data_Valid = 1'b0;
    bus.Data_In = 2'b00;
    repeat (2) tick();
    Reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_out", bus.Data_Out, 0);
      check("rst_ready", bus.Ready, 1);
      check("rst_busy", bus.Busy, 0);
      check("rst_symerr", bus.Sym_Err, 0);
    end

    // 2: single symbol latency and Busy fall
    b2 = 4'b1110;
    push(2'b01, 4'b1110, 1'b1);
    check("t2_busy_q", bus.Busy, 1);
    check("t2_line_pre", bus.Data_Out, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t2_bit", bus.Data_Out, b2[3-i]);
    end
    check("t2_busy_last", bus.Busy, 1);
    @(posedge clk);
    @(negedge clk);
    check("t2_line_end", bus.Data_Out, 0);
    check("t2_busy_end", bus.Busy, 0);

    // 3: back-to-back frames (or gapped with the macro)
    tick();
    starts.delete();
    push(2'b01, 4'b1110, 1'b1);
    push(2'b10, 4'b1000, 1'b1);
    push(2'b01, 4'b1110, 1'b1);
    wait_idle();
    check("t3_nframes", starts.size(), 3);
    if (starts.size() == 3) begin
      check("t3_space0", starts[1] - starts[0], 4 + GapBits);
      check("t3_space1", starts[2] - starts[1], 4 + GapBits);
    end

    // 4: fill FIFO with Enable low, then release
    bus.Enable = 1'b0;
    push(2'b01, 4'b1110, 1'b1);
    push(2'b10, 4'b1000, 1'b1);
    push(2'b10, 4'b1000, 1'b1);
    push(2'b01, 4'b1110, 1'b1);
    check("t4_ready_full", bus.Ready, 0);
    check("t4_busy_full", bus.Busy, 1);
    bus.Data_In = 2'b01;
    bus.Data_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_ready_hold", bus.Ready, 0);
      check("t4_line_hold", bus.Data_Out, 0);
    end
    bus.Data_Valid = 1'b0;
    bus.Enable = 1'b1;
    check("t4_ready_prepop", bus.Ready, 0);
    tick();
    check("t4_ready_postpop", bus.Ready, 1);
    check("t4_first_bit", bus.Data_Out, 1);
    wait_idle();
    check("t4_drained", exp_q.size(), 0);

    // 5: illegal symbols
    push(2'b00, 4'b0000, 1'b0);
    check("t5_err00", bus.Sym_Err, 1);
    check("t5_busy00", bus.Busy, 0);
    tick();
    check("t5_err00_clr", bus.Sym_Err, 0);
    push(2'b11, 4'b0000, 1'b0);
    check("t5_err11", bus.Sym_Err, 1);
    check("t5_ready11", bus.Ready, 1);
    tick();
    check("t5_err11_clr", bus.Sym_Err, 0);
    check("t5_busy_end", bus.Busy, 0);
    check("t5_line", bus.Data_Out, 0);

    // 6: reset on second bit with two symbols queued
    push(2'b01, 4'b1110, 1'b1);
    push(2'b10, 4'b1000, 1'b1);
    push(2'b01, 4'b1110, 1'b1);
    check("t6_bit1", bus.Data_Out, 1);
    Reset = 1'b1;
    exp_q.delete();
    tick();
    Reset = 1'b0;
    check("t6_line", bus.Data_Out, 0);
    check("t6_busy", bus.Busy, 0);
    check("t6_ready", bus.Ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t6_quiet", bus.Data_Out, 0);
    end

    check("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
